f51m_stim_gen: RTL and testbench

//  Sequential stimulus stage directly upstream of the combinational f51m core.
//  - Generates a programmable-length burst of 8-bit input vectors.
//  - Two modes: exhaustive counter, or maximal-length Galois LFSR.
//  - Hands vectors off over a valid/ready link; the consumer registers each one

---
 rtl/f51m_stim_gen.sv | 141 ++++++++++++++
 tb/tb_f51m_stim_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/f51m_stim_gen.sv
// ---------------------------------------------------------------------------
// f51m_stim_gen
// Sequential stimulus stage in front of the combinational f51m core. It emits
// a programmable-length burst of WIDTH-bit vectors over a valid/ready link.
// There are two sequence modes: an exhaustive counter, or a maximal-length
// Galois LFSR.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   start      begin a burst (sampled only in IDLE)
//   mode       0 = counter, 1 = LFSR (latched at start)
//   seed       first vector (latched at start)
//   count      number of vectors in the burst (latched at start)
//   abort      terminate the burst early (honoured in RUN only)
//   vec_out    current vector; bit0 drives core input 1
//   vec_valid  vec_out holds a vector
//   vec_ready  consumer accepts vec_out this cycle
//   busy       high in RUN and FIN
//   done       one-cycle pulse at burst end
//   sent       transfers completed in the current or last burst
// ---------------------------------------------------------------------------
module f51m_stim_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [WIDTH-1:0] vec_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_reg;
    logic             mode_reg;
    logic [CNT_W-1:0] count_reg;

    logic             xfer;
    logic [CNT_W-1:0] sent_inc;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] adv_vec;
    logic [WIDTH-1:0] first_vec;

    assign xfer     = vec_valid & vec_ready;
    assign sent_inc = sent + CNT_W'(1);
    assign cnt_next = vec_out + WIDTH'(1);

    // Right-shifting Galois LFSR: the bit shifted out of position 0 is fed
    // back into every tapped position.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_lfsr
            assign lfsr_next[gi] = vec_out[gi+1] ^ (vec_out[0] & TAPS[gi]);
        end
    endgenerate
    assign lfsr_next[WIDTH-1] = vec_out[0] & TAPS[WIDTH-1];

    assign adv_vec = mode_reg ? lfsr_next : cnt_next;

    // The LFSR locks up at zero, so a zero seed in LFSR mode becomes 1.
    // The input mode is used here because mode_reg is only loaded on the
    // same edge.
    assign first_vec = (mode && (seed == '0)) ? WIDTH'(1) : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mode_reg  <= 1'b0;
            count_reg <= '0;
            vec_out   <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sent      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg  <= mode;
                        count_reg <= count;
                        sent      <= '0;
                        busy      <= 1'b1;
                        if (count != '0) begin
                            state_reg <= RUN;
                            vec_out   <= first_vec;
                            vec_valid <= 1'b1;
                        end else begin
                            // An empty burst goes straight to FIN and never
                            // drives a vector.
                            state_reg <= FIN;
                            done      <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    // A transfer in the same cycle as abort still counts.
                    if (xfer) begin
                        sent    <= sent_inc;
                        vec_out <= adv_vec;
                    end
                    if ((xfer && (sent_inc == count_reg)) || abort) begin
                        state_reg <= FIN;
                        vec_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                FIN: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    vec_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f51m_stim_gen.sv
module tb_f51m_stim_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [7:0]  seed;
    logic [15:0] count;
    logic        abort;
    logic [7:0]  vec_out;
    logic        vec_valid;
    logic        vec_ready;
    logic        busy;
    logic        done;
    logic [15:0] sent;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    f51m_stim_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .count     (count),
        .abort     (abort),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .busy      (busy),
        .done      (done),
        .sent      (sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected vector per transfer and checks
    // the hold rule during stalls.
    logic       prev_stall = 1'b0;
    logic       prev_abort = 1'b0;
    logic [7:0] prev_out   = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                chk("hold_valid", {31'd0, vec_valid}, 32'd1);
                chk("hold_vec", {24'd0, vec_out}, {24'd0, prev_out});
            end
            if (vec_valid && vec_ready) begin
                got_q.push_back(vec_out);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xfer actual=%0h required=none", vec_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    $display("xfer vec=%02h exp=%02h sent=%0d", vec_out, e, sent);
                    chk("xfer_vec", {24'd0, vec_out}, {24'd0, e});
                end
            end
            prev_stall = vec_valid && !vec_ready;
            prev_abort = abort;
            prev_out   = vec_out;
        end
    end

    task automatic push_vecs(input logic m, input logic [7:0] s, input int n);
        logic [7:0] v;
        v = (m && s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            if (m) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
            else   v = v + 8'h01;
        end
    endtask

    task automatic start_burst(input logic m, input logic [7:0] s, input logic [15:0] c);
        @(posedge clk); #1;
        mode = m; seed = s; count = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_sent, input int exp_cycles, input int bound);
        int cyc;
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end else begin
            $display("done %s sent=%0d cycles=%0d", name, sent, cyc);
            chk({name, "_sent"}, {16'd0, sent}, exp_sent);
            chk({name, "_fin_valid"}, {31'd0, vec_valid}, 32'd0);
            chk({name, "_fin_busy"}, {31'd0, busy}, 32'd1);
            chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
            if (exp_cycles > 0) chk({name, "_cycles"}, cyc, exp_cycles);
            @(negedge clk);
            chk({name, "_idle_done"}, {31'd0, done}, 32'd0);
            chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk({name, "_sent_hold"}, {16'd0, sent}, exp_sent);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = 8'h00;
        count = 16'd0; abort = 1'b0; vec_ready = 1'b1;
        #1;
        chk("rst_vec", {24'd0, vec_out}, 32'd0);
        chk("rst_valid", {31'd0, vec_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sent", {16'd0, sent}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: counter wrap FE,FF,00,01
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        start_burst(1'b0, 8'hFE, 16'd4);
        wait_done("t1", 4, 5, 30);

        // 2: LFSR with zero seed
        exp_q.push_back(8'h01); exp_q.push_back(8'hB8); exp_q.push_back(8'h5C);
        exp_q.push_back(8'h2E); exp_q.push_back(8'h17);
        start_burst(1'b1, 8'h00, 16'd5);
        wait_done("t2", 5, 6, 30);

        // 3: full LFSR period
        push_vecs(1'b1, 8'h01, 256);
        got_q.delete();
        start_burst(1'b1, 8'h01, 16'd256);
        wait_done("t3", 256, 257, 300);
        begin
            bit seen [256];
            int ndist;
            ndist = 0;
            for (int i = 0; i < 256; i++) seen[i] = 1'b0;
            for (int i = 0; i < 255 && i < got_q.size(); i++) begin
                if (got_q[i] != 8'h00 && !seen[got_q[i]]) begin
                    seen[got_q[i]] = 1'b1;
                    ndist++;
                end
            end
            chk("t3_distinct", ndist, 32'd255);
            chk("t3_count", got_q.size(), 32'd256);
            if (got_q.size() == 256) chk("t3_wrap", {24'd0, got_q[255]}, 32'h01);
        end

        // 4: stall three cycles after first valid
        vec_ready = 1'b0;
        exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        start_burst(1'b0, 8'h10, 16'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", {31'd0, vec_valid}, 32'd1);
            chk("t4_stall_vec", {24'd0, vec_out}, 32'h10);
        end
        @(posedge clk); #1;
        vec_ready = 1'b1;
        wait_done("t4", 3, -1, 30);

        // 5: empty burst
        start_burst(1'b0, 8'h33, 16'd0);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_valid", {31'd0, vec_valid}, 32'd0);
        wait_done("t5", 0, 1, 10);

        // 6a: abort coinciding with a transfer
        push_vecs(1'b0, 8'h20, 3);
        start_burst(1'b0, 8'h20, 16'd100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("t6a", 3, -1, 10);

        // 6b: abort while stalled
        push_vecs(1'b0, 8'h40, 2);
        start_burst(1'b0, 8'h40, 16'd100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vec_ready = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b1; abort = 1'b0;
        wait_done("t6b", 2, -1, 10);

        // 6c: asynchronous reset mid-burst
        push_vecs(1'b0, 8'h60, 3);
        start_burst(1'b0, 8'h60, 16'd100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6c_rst_valid", {31'd0, vec_valid}, 32'd0);
        chk("t6c_rst_vec", {24'd0, vec_out}, 32'd0);
        chk("t6c_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6c_rst_done", {31'd0, done}, 32'd0);
        chk("t6c_rst_sent", {16'd0, sent}, 32'd0);
        chk("t6c_queue_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int ndone;
            ndone = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done || busy || vec_valid) ndone++;
            end
            chk("t6c_no_done", ndone, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
